// File: rtl/ball_controller.sv
// Ping-pong ball driver: moves a one-hot ball along the LED bar, judges returns
// and misses at either end, and speeds the rally up after every hit.
`timescale 1ns/1ps
module ball_controller #(
  parameter int NUM_LEDS        = 18,
  parameter int STEP_CYCLES     = 12_500_000,
  parameter int SPEEDUP_CYCLES  = 1_000_000,
  parameter int MIN_STEP_CYCLES = 2_500_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               btn_l,
  input  logic                               btn_r,
  input  logic                               game_over,
  output logic [NUM_LEDS-1:0]                leds,
  output logic                               dir_l,
  output logic                               hit_l,
  output logic                               hit_r,
  output logic                               miss_l,
  output logic                               miss_r,
  output logic                               serving,
  output logic [$clog2(STEP_CYCLES+1)-1:0]   step_period
);

  localparam int PW = $clog2(STEP_CYCLES + 1);
  localparam int XW = $clog2(NUM_LEDS);
  localparam logic [XW-1:0] LAST      = XW'(NUM_LEDS - 1);
  localparam logic [PW-1:0] STEP_INIT = PW'(STEP_CYCLES);
  localparam logic [PW-1:0] MIN_P     = PW'(MIN_STEP_CYCLES);
  localparam logic [PW-1:0] SPEED_P   = PW'(SPEEDUP_CYCLES);
  localparam longint FLOOR_KNEE = longint'(MIN_STEP_CYCLES) + longint'(SPEEDUP_CYCLES);

  typedef enum logic [1:0] {SERVE, MOVE, AT_END, HALT} state_t;

  // Shorten the step period, saturating at the floor instead of underflowing.
  function automatic logic [PW-1:0] speedup_period(input logic [PW-1:0] p);
    if (longint'(p) >= FLOOR_KNEE) return p - SPEED_P;
    else return MIN_P;
  endfunction

  function automatic logic [NUM_LEDS-1:0] onehot(input logic [XW-1:0] p);
    return NUM_LEDS'(1) << p;
  endfunction

  logic sync_l_p0, sync_l_p1, sync_l_p2, press_l;
  logic sync_r_p0, sync_r_p1, sync_r_p2, press_r;

  state_t        state, state_n;
  logic [XW-1:0] pos, pos_n;
  logic [PW-1:0] cnt, cnt_n, period_n;
  logic          dir_n, hit_l_n, hit_r_n, miss_l_n, miss_r_n, serving_n;
  logic [NUM_LEDS-1:0] leds_n;
  logic          at_left, tc, end_press;

  // Input stage: two-flop synchroniser, then edge register producing a one-cycle press
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_l_p0 <= 1'b0;
      sync_l_p1 <= 1'b0;
      sync_l_p2 <= 1'b0;
      press_l   <= 1'b0;
      sync_r_p0 <= 1'b0;
      sync_r_p1 <= 1'b0;
      sync_r_p2 <= 1'b0;
      press_r   <= 1'b0;
    end else begin
      sync_l_p0 <= btn_l;
      sync_l_p1 <= sync_l_p0;
      sync_l_p2 <= sync_l_p1;
      press_l   <= sync_l_p1 & ~sync_l_p2;
      sync_r_p0 <= btn_r;
      sync_r_p1 <= sync_r_p0;
      sync_r_p2 <= sync_r_p1;
      press_r   <= sync_r_p1 & ~sync_r_p2;
    end
  end

  // The ball's end decides both who serves and who owns the return.
  assign at_left   = (pos == LAST);
  assign end_press = at_left ? press_l : press_r;
  assign tc        = (cnt == step_period - PW'(1));

  always_comb begin
    state_n  = state;
    pos_n    = pos;
    cnt_n    = cnt;
    dir_n    = dir_l;
    period_n = step_period;
    hit_l_n  = 1'b0;
    hit_r_n  = 1'b0;
    miss_l_n = 1'b0;
    miss_r_n = 1'b0;
    if (game_over) begin
      state_n = HALT;
    end else begin
      case (state)
        SERVE: begin
          cnt_n = '0;
          if (end_press) begin
            state_n = MOVE;
            dir_n   = ~at_left;
          end
        end
        MOVE: begin
          if (tc) begin
            cnt_n = '0;
            if (dir_l) pos_n = pos + XW'(1);
            else       pos_n = pos - XW'(1);
            if ((dir_l && pos == LAST - XW'(1)) || (!dir_l && pos == XW'(1)))
              state_n = AT_END;
          end else begin
            cnt_n = cnt + PW'(1);
          end
        end
        AT_END: begin
          if (end_press) begin
            hit_l_n  = at_left;
            hit_r_n  = ~at_left;
            dir_n    = ~dir_l;
            period_n = speedup_period(step_period);
            cnt_n    = '0;
            state_n  = MOVE;
          end else if (tc) begin
            miss_l_n = at_left;
            miss_r_n = ~at_left;
            cnt_n    = '0;
            state_n  = SERVE;
          end else begin
            cnt_n = cnt + PW'(1);
          end
        end
        HALT: state_n = HALT;
        default: state_n = HALT;
      endcase
    end
    leds_n    = (state_n == HALT) ? '0 : onehot(pos_n);
    serving_n = (state_n == SERVE);
  end

  // Game stage: state, position, timing and every output are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SERVE;
      pos         <= '0;
      cnt         <= '0;
      dir_l       <= 1'b1;
      step_period <= STEP_INIT;
      leds        <= NUM_LEDS'(1);
      hit_l       <= 1'b0;
      hit_r       <= 1'b0;
      miss_l      <= 1'b0;
      miss_r      <= 1'b0;
      serving     <= 1'b1;
    end else begin
      state       <= state_n;
      pos         <= pos_n;
      cnt         <= cnt_n;
      dir_l       <= dir_n;
      step_period <= period_n;
      leds        <= leds_n;
      hit_l       <= hit_l_n;
      hit_r       <= hit_r_n;
      miss_l      <= miss_l_n;
      miss_r      <= miss_r_n;
      serving     <= serving_n;
    end
  end

endmodule

// File: doc/ball_controller.md
# ball_controller

Drives the ball across the one-hot LED bar for the ping-pong game and is the stage directly upstream of the score controller. It produces `leds`, whose end bits `leds[0]` and `leds[NUM_LEDS-1]` the score controller samples on each button press. It also generates per-player hit and miss pulses, and shortens the step period after every return. It runs on the system clock, synchronises both player buttons internally, and freezes on a game-over input built from the score controller's full flags.

## Interface
- `NUM_LEDS`, default 18: length of the LED bar. Legal range is 4 or more.
- `STEP_CYCLES`, default 12_500_000: initial clock cycles per ball step.
- `SPEEDUP_CYCLES`, default 1_000_000: amount subtracted from the step period on each successful hit.
- `MIN_STEP_CYCLES`, default 2_500_000: floor for the step period. Must satisfy 1 ≤ MIN ≤ STEP.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-high.
- `btn_l` in 1: left player button, raw and active-high. Left player owns `leds[NUM_LEDS-1]`.
- `btn_r` in 1: right player button, raw and active-high. Right player owns `leds[0]`.
- `game_over` in 1: level input, high when either full flag is set.
- `leds` out NUM_LEDS: one-hot ball position, or all-zero in HALT.
- `dir_l` out 1: 1 = ball travelling toward `leds[NUM_LEDS-1]`.
- `hit_l` out 1: one-cycle pulse when the left player returns the ball.
- `hit_r` out 1: one-cycle pulse when the right player returns the ball.
- `miss_l` out 1: one-cycle pulse when the left player misses.
- `miss_r` out 1: one-cycle pulse when the right player misses.
- `serving` out 1: high in SERVE.
- `step_period` out $clog2(STEP_CYCLES+1): current step period.

## Operation
**Button input**
- Each button goes through a 2-FF synchroniser, then a rising-edge detector, producing `press_l` / `press_r`.
- Each press pulse lasts one cycle.

**State machine** (states SERVE, MOVE, AT_END, HALT)
- **SERVE**: ball parked at the server's end; step counter held at 0.
  - Only the server's press is accepted. It moves to MOVE with direction set away from the server.
  - All other presses are ignored.
- **MOVE**: the step counter counts 0..step_period-1. On the terminal count:
  - position moves one LED in `dir_l`;
  - the counter clears;
  - if the new position is the far end, the state goes to AT_END.
- **AT_END**: dwell of one full step period while the ball sits on the owning player's LED.
  - Owner press: pulse `hit_*`, flip `dir_l`, set step_period = max(step_period − SPEEDUP_CYCLES, MIN_STEP_CYCLES), clear the counter, return to MOVE.
  - The first MOVE step after a hit therefore leaves the end LED one new period later.
  - Counter terminal count with no owner press: pulse `miss_*` for the owner, go to SERVE. The missing player serves and the ball stays on their end LED.
- **HALT**: entered from any state on the cycle `game_over` is high.
  - `leds` = 0, all pulses held low, `serving` = 0.
  - Left only by `rst`.

**Rules**
- Non-owner presses, and presses while the ball is not at an end, are ignored with no penalty.
- Position arithmetic never wraps. Position stays within 0..NUM_LEDS-1 by construction.
- `step_period` is not reset on a miss. Only `rst` restores STEP_CYCLES.

**Reset values**
- State SERVE, server = right, ball at `leds[0]`, so `leds` = 1.
- `dir_l` = 1, `step_period` = STEP_CYCLES, counter = 0.
- Synchroniser and edge registers = 0; all pulses and `serving` as they follow from SERVE (`serving` = 1).

## Timing
- Button rising edge to press pulse: 3 cycles (2 sync + edge register). All outputs are registered.
- `hit_*` / `miss_*` assert on the cycle after the deciding event: the press pulse or the counter terminal count.
- On the same cycle as the hit pulse:
  - `dir_l` updates;
  - `step_period` shows the new value;
  - for a miss, `serving` rises.
- SERVE→MOVE: `serving` falls 1 cycle after the press pulse. The first LED move occurs step_period cycles later.
- MOVE step: `leds` shifts on the cycle after terminal count (count = step_period-1).
- Boundary cases:
  - Owner press on the same cycle as the AT_END terminal count: hit wins, no miss.
  - Both players press on the same cycle: only the owner's press counts.
  - `game_over` on the same cycle as a hit or miss: HALT wins and no pulse is emitted.
  - `rst` asserted mid-flight: reset values on the next edge, regardless of state.

## Test plan
Parameters for all scenarios: NUM_LEDS=6, STEP=8, SPEEDUP=3, MIN=4.

1. **Reset and serve**: after `rst`, `leds`=6'b000001 and `serving`=1. Pulse `btn_r` → `serving`=0 after 4 cycles; `leds`=000010 after 8 more cycles; reaches 100000 after 5 steps, state AT_END.
2. **Left return and speedup**: with the ball at 100000, pulse `btn_l` → `hit_l`=1 for one cycle, `dir_l`=0, `step_period`=5. Second return → `step_period`=4. Third return → `step_period` stays 4.
3. **Miss**: no press during the 8-cycle dwell at 100000 → `miss_l` one-cycle pulse, `serving`=1, `leds` stays 100000. `btn_r` is ignored; `btn_l` serves with `dir_l`=0.
4. **Ignored presses**: `btn_l` and `btn_r` while the ball is at 001000 → no pulses and no direction change. `btn_r` at 100000 → no hit, and a miss follows for the left player.
5. **Simultaneous events**: owner press arranged to hit exactly the terminal-count cycle → `hit` only, no `miss`. Both buttons on the same cycle at 000001 → `hit_r` only.
6. **Game over and reset**: raise `game_over` mid-MOVE → `leds`=0 next cycle; no pulses for any button activity. `rst` → `leds`=000001, `step_period`=8.
